// File: rtl/mtr_pkg.sv
// mtr_pkg: shared types and helpers for the motor PWM generator.
//   pwm_state_t - generator FSM states
//   CNT_W_DEF   - default period counter width (period = 2**CNT_W_DEF clk)
//   DUTY_W_DEF  - default signed duty width (always CNT_W_DEF + 1)
//   abs_sat()   - magnitude of a 32-bit signed value, saturating the most
//                 negative input to the largest positive value
package mtr_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} pwm_state_t;

    localparam int CNT_W_DEF  = 11;
    localparam int DUTY_W_DEF = 12;

    function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
        logic [31:0] r;
        if (!v[31]) begin
            r = v;
        end else if (v == {1'b1, {31{1'b0}}}) begin
            r = 32'h7FFF_FFFF;
        end else begin
            r = -v;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// pwm_period_cnt: free-running PWM period counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to 0 (has priority over inc)
//   inc        - advance by one; wraps naturally from all-ones to 0
//   cnt        - current count
//   wrap       - cnt is at its last value of the period (all ones)
//   zero       - cnt is 0 (first cycle of a period)
module pwm_period_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wrap = (cnt == {CNT_W{1'b1}});
    assign zero = (cnt == '0);

endmodule

// File: rtl/mtr_pwm_gen.sv
// mtr_pwm_gen: complementary PWM generator for one motor half-bridge.
// A signed duty command becomes a direction bit plus a high/low PWM pair that
// feeds the dead-time stage. New duty values are taken only at period
// boundaries; dropping en finishes the current period before stopping.
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - drive enable (level)
//   duty         - signed duty command (two's complement, DUTY_W = CNT_W+1)
//   duty_vld     - 1-cycle strobe capturing duty into the pending register
//   high_out     - high-side PWM
//   low_out      - low-side PWM, complement of high_out while running
//   dir          - 1 = reverse, held for the whole active period
//   period_start - 1-cycle pulse on the first cycle of each running period
//   busy         - FSM is not IDLE
module mtr_pwm_gen
    import mtr_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DUTY_W = DUTY_W_DEF   // must be CNT_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    input  logic              duty_vld,
    output logic              high_out,
    output logic              low_out,
    output logic              dir,
    output logic              period_start,
    output logic              busy
);

    pwm_state_t        state, stateNxt;
    logic              cntClr, cntInc, cntWrap, cntZero;
    logic [CNT_W-1:0]  cnt;
    logic              loadShadow;

    logic [31:0]       dutyAbs;
    logic [DUTY_W-1:0] dutyMag;
    logic [DUTY_W-1:0] pendMag, shadowMag, effMag;
    logic              pendDir, shadowDir, effDir;
    logic              running, pwmOn;

    pwm_period_cnt #(.CNT_W(CNT_W)) uCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cntClr),
        .inc   (cntInc),
        .cnt   (cnt),
        .wrap  (cntWrap),
        .zero  (cntZero)
    );

    // |duty| fits DUTY_W unsigned bits (the most negative value maps to
    // 2**CNT_W); the saturation only matters for out-of-range widths.
    assign dutyAbs = abs_sat({{(32-DUTY_W){duty[DUTY_W-1]}}, duty});
    assign dutyMag = (|dutyAbs[31:DUTY_W]) ? {DUTY_W{1'b1}} : dutyAbs[DUTY_W-1:0];

    // A strobe in the same cycle as a shadow load bypasses the pending reg.
    assign effMag = duty_vld ? dutyMag : pendMag;
    assign effDir = duty_vld ? duty[DUTY_W-1] : pendDir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        cntClr     = 1'b0;
        cntInc     = 1'b0;
        loadShadow = 1'b0;
        unique case (state)
            IDLE: begin
                cntClr = 1'b1;
                if (en) stateNxt = START;
            end
            START: begin
                cntClr     = 1'b1;
                loadShadow = 1'b1;
                stateNxt   = RUN;
            end
            RUN: begin
                cntInc = 1'b1;
                // en is only looked at on the last cycle, so a period is
                // never cut short.
                if (cntWrap) begin
                    loadShadow = 1'b1;
                    if (!en) stateNxt = STOP;
                end
            end
            STOP: begin
                // Always return via IDLE, giving at least two off cycles.
                cntClr   = 1'b1;
                stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendMag <= '0;
            pendDir <= 1'b0;
        end else if (duty_vld) begin
            pendMag <= dutyMag;
            pendDir <= duty[DUTY_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadowMag <= '0;
            shadowDir <= 1'b0;
        end else if (loadShadow) begin
            shadowMag <= effMag;
            shadowDir <= effDir;
        end
    end

    // shadowMag has one extra bit, so a full-scale duty (2**CNT_W) keeps
    // pwmOn true for every count, including the wrap cycle.
    assign running = (state == RUN);
    assign pwmOn   = ({1'b0, cnt} < shadowMag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_out     <= 1'b0;
            low_out      <= 1'b0;
            dir          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            high_out     <= running & pwmOn;
            low_out      <= running & ~pwmOn;
            period_start <= running & cntZero;
            if (running) dir <= shadowDir;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mtr_pwm_gen.sv
module tb_mtr_pwm_gen;

    localparam int CW  = 4;
    localparam int DW  = 5;
    localparam int PER = 16;

    logic          clk = 1'b0;
    logic          rst_n, en, duty_vld;
    logic [DW-1:0] duty;
    logic          high_out, low_out, dir, period_start, busy;

    int checks = 0;
    int errors = 0;

    mtr_pwm_gen #(.CNT_W(CW), .DUTY_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty         (duty),
        .duty_vld     (duty_vld),
        .high_out     (high_out),
        .low_out      (low_out),
        .dir          (dir),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assert property (@(posedge clk) !(high_out && low_out))
        else $error("FAIL overlap: high_out and low_out both 1");

    // Reference model: mode 0 off, 1 starting, 2 running, 3 stopping.
    // pos is the position within the running period.
    int m_mode, m_pos, m_smag, m_pmag, m_vmag;
    bit m_sneg, m_pneg, m_vneg;
    bit e_high, e_low, e_dir, e_ps;
    wire e_busy = (m_mode != 0);

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_smag = 0; m_pmag = 0;
            m_sneg = 0; m_pneg = 0;
            e_high = 0; e_low = 0; e_dir = 0; e_ps = 0;
        end else begin
            m_vmag = duty_vld ? iabs(int'($signed(duty))) : m_pmag;
            m_vneg = duty_vld ? (int'($signed(duty)) < 0) : m_pneg;
            e_high = (m_mode == 2) && (m_pos < m_smag);
            e_low  = (m_mode == 2) && !(m_pos < m_smag);
            e_ps   = (m_mode == 2) && (m_pos == 0);
            if (m_mode == 2) e_dir = m_sneg;
            case (m_mode)
                0: if (en) m_mode = 1;
                1: begin m_smag = m_vmag; m_sneg = m_vneg; m_pos = 0; m_mode = 2; end
                2: begin
                    if (m_pos == PER - 1) begin
                        m_smag = m_vmag; m_sneg = m_vneg;
                        if (!en) m_mode = 3;
                    end
                    m_pos = (m_pos + 1) % PER;
                end
                default: m_mode = 0;
            endcase
            if (duty_vld) begin m_pmag = m_vmag; m_pneg = m_vneg; end
        end
    end

    // Stimulus helpers (no checking inside).
    task automatic strobe(input int v);
        duty = DW'(v); duty_vld = 1'b1;
        @(negedge clk); duty_vld = 1'b0;
        @(negedge clk);
    endtask

    // Finds the next period_start, counts high/low over 16 cycles and reports
    // whether the following period_start arrives exactly one period later.
    task automatic meas(output int hc, output int lc, output int d, output int pd, output int ok);
        int to;
        to = 0; pd = int'(dir);
        while (!period_start && to < 40) begin
            pd = int'(dir); @(negedge clk); to++;
        end
        hc = 0; lc = 0; d = int'(dir); ok = 0;
        if (period_start) begin
            for (int i = 0; i < PER; i++) begin
                hc += int'(high_out); lc += int'(low_out); @(negedge clk);
            end
            ok = int'(period_start);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; duty = '0; duty_vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({high_out, low_out, dir, period_start, busy} !== 5'b0) begin
            errors++; $display("FAIL reset outs got %b exp 00000", {high_out, low_out, dir, period_start, busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int hc, lc, d, pd, ok;
        strobe(5);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || high_out !== 1'b0) begin
            errors++; $display("FAIL basic_busy got busy=%b high=%b exp 1 0", busy, high_out);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({high_out, low_out, dir, period_start, busy} !== {e_high, e_low, e_dir, e_ps, e_busy}) begin
                errors++; $display("FAIL basic_model cyc %0d got %b exp %b", i,
                    {high_out, low_out, dir, period_start, busy}, {e_high, e_low, e_dir, e_ps, e_busy});
            end
        end
        for (int p = 0; p < 2; p++) begin
            meas(hc, lc, d, pd, ok);
            checks++;
            if (hc != 5 || lc != 11 || d != 0 || ok != 1) begin
                errors++; $display("FAIL basic_period %0d got h=%0d l=%0d dir=%0d ps16=%0d exp 5 11 0 1", p, hc, lc, d, ok);
            end
        end
    endtask

    task automatic test_sign_change;
        int hc, lc, d, pd, ok, to;
        for (to = 0; to < 40 && !(m_mode == 2 && m_pos == 7); to++) @(negedge clk);
        checks++;
        if (!(m_mode == 2 && m_pos == 7)) begin
            errors++; $display("FAIL sign_wait timeout got pos=%0d exp 7", m_pos);
        end
        strobe(-12);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({high_out, low_out, dir, period_start} !== {e_high, e_low, e_dir, e_ps}) begin
                errors++; $display("FAIL sign_tail cyc %0d got %b exp %b", i,
                    {high_out, low_out, dir, period_start}, {e_high, e_low, e_dir, e_ps});
            end
        end
        meas(hc, lc, d, pd, ok);
        checks++;
        if (hc != 12 || lc != 4 || d != 1 || pd != 0 || ok != 1) begin
            errors++; $display("FAIL sign_period got h=%0d l=%0d dir=%0d prevdir=%0d ps16=%0d exp 12 4 1 0 1", hc, lc, d, pd, ok);
        end
    endtask

    task automatic test_boundaries;
        int hc, lc, d, pd, ok;
        strobe(0);
        meas(hc, lc, d, pd, ok);
        checks++;
        if (hc != 0 || lc != 16 || d != 0 || ok != 1) begin
            errors++; $display("FAIL zero_duty got h=%0d l=%0d dir=%0d ps16=%0d exp 0 16 0 1", hc, lc, d, ok);
        end
        strobe(-16);
        for (int p = 0; p < 2; p++) begin
            meas(hc, lc, d, pd, ok);
            checks++;
            if (hc != 16 || lc != 0 || d != 1 || ok != 1) begin
                errors++; $display("FAIL full_duty %0d got h=%0d l=%0d dir=%0d ps16=%0d exp 16 0 1 1", p, hc, lc, d, ok);
            end
        end
    endtask

    task automatic test_stop;
        int hc, lc, d, pd, ok, to;
        strobe(5);
        meas(hc, lc, d, pd, ok);
        for (to = 0; to < 40 && !(m_mode == 2 && m_pos == 3); to++) @(negedge clk);
        en = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if ({high_out, low_out, dir, period_start, busy} !== {e_high, e_low, e_dir, e_ps, e_busy}) begin
                errors++; $display("FAIL stop_model k=%0d got %b exp %b", k,
                    {high_out, low_out, dir, period_start, busy}, {e_high, e_low, e_dir, e_ps, e_busy});
            end
            if (k == 13) begin
                checks++;
                if (busy !== 1'b1 || (high_out | low_out) !== 1'b1) begin
                    errors++; $display("FAIL stop_last got busy=%b h=%b l=%b exp busy=1 pwm active", busy, high_out, low_out);
                end
            end
            if (k == 14) begin
                checks++;
                if (busy !== 1'b0 || high_out !== 1'b0 || low_out !== 1'b0) begin
                    errors++; $display("FAIL stop_idle got busy=%b h=%b l=%b exp 0 0 0", busy, high_out, low_out);
                end
            end
        end
        // Re-raise en while in STOP: must still pass through IDLE.
        en = 1'b1;
        for (to = 0; to < 10 && m_mode != 2; to++) @(negedge clk);
        repeat (3) @(negedge clk);
        en = 1'b0;
        for (to = 0; to < 40 && m_mode != 3; to++) @(negedge clk);
        checks++;
        if (m_mode != 3 || busy !== 1'b1) begin
            errors++; $display("FAIL stop_wait got busy=%b exp 1 in stop", busy);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL restart_idle got busy=%b exp 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL restart_start got busy=%b exp 1", busy);
        end
    endtask

    task automatic test_wrap_strobe;
        int hc, lc, d, pd, ok, to;
        for (to = 0; to < 40 && !(m_mode == 2 && m_pos == 15); to++) @(negedge clk);
        strobe(9);
        meas(hc, lc, d, pd, ok);
        checks++;
        if (hc != 9 || lc != 7 || d != 0 || ok != 1) begin
            errors++; $display("FAIL wrap_bypass got h=%0d l=%0d dir=%0d ps16=%0d exp 9 7 0 1", hc, lc, d, ok);
        end
    endtask

    task automatic test_async_reset;
        int hc, lc, d, pd, ok;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0; en = 1'b0;
        #1;
        checks++;
        if ({high_out, low_out, dir, period_start, busy} !== 5'b0) begin
            errors++; $display("FAIL async_reset got %b exp 00000", {high_out, low_out, dir, period_start, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got busy=%b exp 0", busy);
        end
        en = 1'b1;
        meas(hc, lc, d, pd, ok);
        checks++;
        if (hc != 0 || lc != 16 || ok != 1) begin
            errors++; $display("FAIL pending_lost got h=%0d l=%0d ps16=%0d exp 0 16 1", hc, lc, ok);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if ({high_out, low_out, dir, period_start, busy} !== {e_high, e_low, e_dir, e_ps, e_busy}) begin
                errors++; $display("FAIL random cyc %0d got %b exp %b", i,
                    {high_out, low_out, dir, period_start, busy}, {e_high, e_low, e_dir, e_ps, e_busy});
            end
            duty     = DW'($urandom_range(0, 31));
            duty_vld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
        end
        duty_vld = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_sign_change;
        test_boundaries;
        test_stop;
        test_wrap_strobe;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
